pipe_rx_deframer: RTL and testbench

Receive-side deframer directly downstream of the host-to-system pipe FIFO. It drives the FIFO's `rx_ready`/`rx_valid` pop handshake, hunts for a sync word and parses a length word, payload and checksum. It forwards the payload on a ready/valid stream with an end-of-frame marker and reports per-frame status and counters to system logic.

---
 rtl/pipe_rx_deframer.sv | 140 ++++++++++++++
 tb/tb_pipe_rx_deframer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rx_deframer.sv
// Receive deframer behind the host pipe FIFO: hunts for a sync word, parses length/payload/checksum,
// forwards the payload through a 3-entry buffer and reports per-frame status and counters.
module pipe_rx_deframer #(
    parameter logic [15:0] SYNC_WORD = 16'hAA55,
    parameter int unsigned MAX_LEN   = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    output logic        rx_ready,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int unsigned RemW   = $clog2(MAX_LEN + 1);
    localparam logic [15:0] MaxLen = 16'(MAX_LEN);

    typedef enum logic [1:0] {StHunt, StLen, StData, StCsum} state_e;

    state_e            state_q;
    logic [RemW-1:0]   rem_q;
    logic [15:0]       sum_q;
    logic              frame_ok_q;
    logic              frame_err_q;
    logic [1:0]        err_code_q;
    logic [15:0]       frame_cnt_q;
    logic [15:0]       err_cnt_q;
    logic              active_q;
    logic              pend_q;

    logic [16:0]       buf_q [3];
    logic [1:0]        rd_ptr_q;
    logic [1:0]        wr_ptr_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Budget counts the word that may already be in flight from the FIFO.
    assign rx_ready  = active_q && (({1'b0, count_q} + {2'b00, pend_q}) < 3'd3);
    assign push      = rx_valid && (state_q == StData);
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_q[rd_ptr_q][15:0];
    assign out_last  = out_valid && buf_q[rd_ptr_q][16];

    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= StHunt;
            rem_q       <= '0;
            sum_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            active_q    <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            active_q    <= 1'b1;
            pend_q      <= rx_ready;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (rx_valid) begin
                unique case (state_q)
                    StHunt: begin
                        if (rx_data == SYNC_WORD) state_q <= StLen;
                    end
                    StLen: begin
                        if (rx_data == 16'd0 || rx_data > MaxLen) begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd1;
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                            state_q     <= StHunt;
                        end else begin
                            rem_q   <= RemW'(rx_data);
                            sum_q   <= rx_data;
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        sum_q <= sum_q + rx_data;
                        rem_q <= rem_q - RemW'(1);
                        if (rem_q == RemW'(1)) state_q <= StCsum;
                    end
                    StCsum: begin
                        if (rx_data == sum_q) begin
                            frame_ok_q  <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'd2;
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        state_q <= StHunt;
                    end
                    default: state_q <= StHunt;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= {rem_q == RemW'(1), rx_data};
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_rx_deframer.sv
// Randomized scoreboard bench for pipe_rx_deframer: a frame-level parser predicts the payload
// stream and status pulses; a monitor pops expectations whenever the DUT presents output.
module tb_pipe_rx_deframer;

    localparam logic [15:0] Sync   = 16'hAA55;
    localparam int          MaxLen = 1024;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        rx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    pipe_rx_deframer #(
        .SYNC_WORD(Sync),
        .MAX_LEN  (MaxLen)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .rx_ready (rx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_code (err_code),
        .frame_cnt(frame_cnt),
        .err_cnt  (err_cnt)
    );

    typedef struct packed {logic last; logic [15:0] data;} out_t;
    typedef struct packed {logic ok; logic [1:0] code; logic [15:0] fc; logic [15:0] ec;} stat_t;

    out_t        exp_out[$];
    stat_t       exp_stat[$];
    logic [15:0] stim_q[$];
    bit          flag_q[$];

    int          checks;
    int          errors;
    logic [15:0] m_fc;
    int          m_ec;
    logic [1:0]  m_code;
    int          gap_pct;
    bit          or_random;
    bit          or_hold;
    bit          rx_is_payload;
    int          last_run;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: walks the word list, records expected payload and status events.
    task automatic model_frames(input logic [15:0] w[$]);
        int          i;
        int          n;
        logic [15:0] sum;
        bit          pay[$];
        for (int j = 0; j < w.size(); j++) pay.push_back(1'b0);
        i = 0;
        while (i < w.size()) begin
            if (w[i] != Sync) begin
                i++;
                continue;
            end
            i++;
            if (i >= w.size()) break;
            n = int'(w[i]);
            i++;
            if (n == 0 || n > MaxLen) begin
                if (m_ec < 65535) m_ec++;
                m_code = 2'd1;
                exp_stat.push_back(stat_t'{ok: 1'b0, code: m_code, fc: m_fc, ec: 16'(m_ec)});
                continue;
            end
            if (i + n >= w.size()) break;
            sum = w[i - 1];
            for (int k = 0; k < n; k++) begin
                pay[i + k] = 1'b1;
                exp_out.push_back(out_t'{last: (k == n - 1), data: w[i + k]});
                sum = sum + w[i + k];
            end
            i += n;
            if (w[i] == sum) begin
                m_fc = m_fc + 16'd1;
                exp_stat.push_back(stat_t'{ok: 1'b1, code: m_code, fc: m_fc, ec: 16'(m_ec)});
            end else begin
                if (m_ec < 65535) m_ec++;
                m_code = 2'd2;
                exp_stat.push_back(stat_t'{ok: 1'b0, code: m_code, fc: m_fc, ec: 16'(m_ec)});
            end
            i++;
        end
        for (int j = 0; j < w.size(); j++) begin
            stim_q.push_back(w[j]);
            flag_q.push_back(pay[j]);
        end
    endtask

    task automatic wait_idle(input string name);
        int idle;
        idle = 0;
        for (int c = 0; c < 3000 && idle < 4; c++) begin
            @(negedge sys_clk);
            if (stim_q.size() == 0 && exp_out.size() == 0 && exp_stat.size() == 0 &&
                !out_valid && !rx_valid) idle++;
            else idle = 0;
        end
        check({"drain_", name}, 32'(idle >= 4), 32'd1);
        check({"frame_cnt_", name}, 32'(frame_cnt), 32'(m_fc));
        check({"err_cnt_", name}, 32'(err_cnt), 32'(m_ec));
        check({"err_code_", name}, 32'(err_code), 32'(m_code));
    endtask

    task automatic rand_frame(input int n, input bit bad, input int garbage);
        logic [15:0] fr[$];
        logic [15:0] sum;
        logic [15:0] g;
        for (int k = 0; k < garbage; k++) begin
            g = 16'($urandom);
            if (g == Sync) g = g ^ 16'h0001;
            fr.push_back(g);
        end
        fr.push_back(Sync);
        fr.push_back(16'(n));
        sum = 16'(n);
        for (int k = 0; k < n; k++) begin
            fr.push_back(16'($urandom));
            sum = sum + fr[fr.size() - 1];
        end
        fr.push_back(bad ? sum ^ 16'(1 + $urandom_range(254)) : sum);
        model_frames(fr);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_last"}, 32'(out_last), 32'd0);
        check({name, "_out_data"}, 32'(out_data), 32'd0);
        check({name, "_frame_ok"}, 32'(frame_ok), 32'd0);
        check({name, "_frame_err"}, 32'(frame_err), 32'd0);
        check({name, "_err_code"}, 32'(err_code), 32'd0);
        check({name, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({name, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    // Pipe FIFO emulation: a word may only follow a cycle in which rx_ready was high.
    initial begin
        bit grant;
        rx_valid      = 1'b0;
        rx_data       = 16'd0;
        rx_is_payload = 1'b0;
        out_ready     = 1'b1;
        forever begin
            @(negedge sys_clk);
            grant = rx_ready && sys_rst_n;
            @(posedge sys_clk);
            #1;
            if (grant && stim_q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                rx_valid      = 1'b1;
                rx_data       = stim_q.pop_front();
                rx_is_payload = flag_q.pop_front();
            end else begin
                rx_valid      = 1'b0;
                rx_is_payload = 1'b0;
            end
            out_ready = or_hold ? 1'b0 : (or_random ? 1'($urandom_range(1)) : 1'b1);
        end
    end

    initial begin
        int    occ;
        int    run_len;
        bit    prev_ready;
        out_t  e;
        stat_t s;
        occ        = 0;
        run_len    = 0;
        prev_ready = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                occ        = 0;
                run_len    = 0;
                prev_ready = 1'b0;
            end else begin
                if (rx_valid && !prev_ready) begin
                    errors++;
                    $display("FAIL rx_protocol: rx_valid=1 without prior rx_ready (t=%0t)", $time);
                end
                prev_ready = rx_ready;
                check("occupancy_valid", 32'(out_valid), 32'(occ != 0));
                check("occupancy_max", 32'(occ <= 3), 32'd1);
                if (out_valid && out_ready) begin
                    if (exp_out.size() == 0) begin
                        check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_out.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                    end
                    run_len++;
                    if (out_last) begin
                        last_run = run_len;
                        run_len  = 0;
                    end
                end else begin
                    run_len = 0;
                end
                if (frame_ok || frame_err) begin
                    if (exp_stat.size() == 0) begin
                        check("unexpected_status", {30'd0, frame_ok, frame_err}, 32'd0);
                    end else begin
                        s = exp_stat.pop_front();
                        check("stat_ok", 32'(frame_ok), 32'(s.ok));
                        check("stat_err", 32'(frame_err), 32'(!s.ok));
                        check("stat_code", 32'(err_code), 32'(s.code));
                        check("stat_fcnt", 32'(frame_cnt), 32'(s.fc));
                        check("stat_ecnt", 32'(err_cnt), 32'(s.ec));
                    end
                end
                occ = occ + int'(rx_valid && rx_is_payload) - int'(out_valid && out_ready);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] fr[$];
        checks    = 0;
        errors    = 0;
        m_fc      = 16'd0;
        m_ec      = 0;
        m_code    = 2'd0;
        gap_pct   = 0;
        or_random = 1'b0;
        or_hold   = 1'b0;
        last_run  = 0;
        sys_rst_n = 1'b0;

        repeat (3) @(negedge sys_clk);
        check_reset_vals("reset");
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rx_ready_release_cycle", 32'(rx_ready), 32'd0);
        @(negedge sys_clk);
        check("rx_ready_next_cycle", 32'(rx_ready), 32'd1);

        fr = '{16'hAA55, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0009};
        model_frames(fr);
        wait_idle("good");

        fr = '{16'hAA55, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h000A};
        model_frames(fr);
        wait_idle("bad_csum");

        fr = '{16'hAA55, 16'h0000, 16'hAA55, 16'h0401,
               16'hAA55, 16'h0002, 16'h0010, 16'h0020, 16'h0032};
        model_frames(fr);
        wait_idle("bad_len");

        fr = '{16'h1234, 16'hAA54, 16'hAA55, 16'h0001, 16'hFFFF, 16'h0000};
        model_frames(fr);
        wait_idle("garbage");

        last_run = 0;
        rand_frame(16, 1'b0, 0);
        wait_idle("throughput");
        check("full_rate_run", 32'(last_run), 32'd16);

        or_random = 1'b1;
        rand_frame(16, 1'b0, 0);
        wait_idle("backpressure");

        gap_pct = 30;
        for (int f = 0; f < 8; f++) begin
            rand_frame(int'($urandom_range(1, 12)), ($urandom_range(2) == 0),
                       int'($urandom_range(2)));
        end
        wait_idle("random");
        gap_pct   = 0;
        or_random = 1'b0;

        // Two payload words parked in the buffer when reset hits.
        or_hold = 1'b1;
        fr = '{16'hAA55, 16'h0005, 16'h1111, 16'h2222};
        for (int j = 0; j < fr.size(); j++) begin
            stim_q.push_back(fr[j]);
            flag_q.push_back(j >= 2);
        end
        repeat (10) @(negedge sys_clk);
        check("parked_valid", 32'(out_valid), 32'd1);
        check("parked_data", 32'(out_data), 32'h1111);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b0;
        exp_out.delete();
        m_fc   = 16'd0;
        m_ec   = 0;
        m_code = 2'd0;
        @(negedge sys_clk);
        check_reset_vals("midreset");
        or_hold = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        fr = '{16'hAA55, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0009};
        model_frames(fr);
        wait_idle("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
